meas_sequencer: RTL and testbench

MEAS_SEQUENCER -- requirements
Module: meas_sequencer

---
 rtl/meas_sequencer_if.sv | 37 +++
 rtl/meas_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_meas_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/meas_sequencer_if.sv
// ---------------------------------------------------------------------------
// Module : meas_sequencer_if
// Brief  : Control, ADC handshake and electrode-select bundle of the sequencer.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface meas_sequencer_if;
    logic       en_single;
    logic       en_twin;
    logic       stop_req;
    logic       adc_done;
    logic [3:0] exc_sel;
    logic [3:0] det_sel;
    logic       plane;
    logic       adc_start;
    logic [9:0] meas_idx;
    logic       meas_valid;
    logic       frame_end;
    logic       busy;
    logic       adc_err;

    // Sequencer side: owns the electrode selection and the conversion trigger.
    modport master (
        input  en_single, en_twin, stop_req, adc_done,
        output exc_sel, det_sel, plane, adc_start, meas_idx,
        output meas_valid, frame_end, busy, adc_err
    );

    modport slave (
        output en_single, en_twin, stop_req, adc_done,
        input  exc_sel, det_sel, plane, adc_start, meas_idx,
        input  meas_valid, frame_end, busy, adc_err
    );
endinterface

`default_nettype wire

// File: rtl/meas_sequencer.sv
// ---------------------------------------------------------------------------
// Module : meas_sequencer
// Brief  : Walks every electrode pair of one or two planes, settles, triggers
//          the ADC and reports each completed conversion.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module meas_sequencer #(
    parameter int NELEC   = 12,
    parameter int SETTLE  = 16,
    parameter int TIMEOUT = 255
) (
    input  wire logic        clk,
    input  wire logic        rst,
    meas_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_SETTLE = 3'd2,
        S_CONV   = 3'd3,
        S_NEXT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [3:0] c_last_exc  = 4'(NELEC - 2);
    localparam logic [3:0] c_last_det  = 4'(NELEC - 1);
    localparam logic [7:0] c_settle_ld = 8'(SETTLE - 1);
    localparam logic [7:0] c_timeout   = 8'(TIMEOUT);

    state_t     r_state;
    logic [3:0] r_exc;
    logic [3:0] r_det;
    logic       r_plane;
    logic       r_adc_start;
    logic [9:0] r_idx;
    logic       r_valid;
    logic       r_frame_end;
    logic       r_busy;
    logic       r_err;
    logic       r_stop;
    logic       r_twin;
    logic [7:0] r_scnt;
    logic [7:0] r_tcnt;

    state_t     w_state;
    logic [3:0] w_exc;
    logic [3:0] w_det;
    logic       w_plane;
    logic       w_adc_start;
    logic [9:0] w_idx;
    logic       w_valid;
    logic       w_frame_end;
    logic       w_busy;
    logic       w_err;
    logic       w_stop;
    logic       w_twin;
    logic [7:0] w_scnt;
    logic [7:0] w_tcnt;
    logic       w_last_pair;

    assign w_last_pair = (r_exc == c_last_exc) && (r_det == c_last_det);

    always_comb begin
        w_state     = r_state;
        w_exc       = r_exc;
        w_det       = r_det;
        w_plane     = r_plane;
        w_adc_start = 1'b0;
        w_idx       = r_idx;
        w_valid     = 1'b0;
        w_frame_end = 1'b0;
        w_err       = r_err;
        w_stop      = r_stop | (bus.stop_req & r_busy);
        w_twin      = r_twin;
        w_scnt      = r_scnt;
        w_tcnt      = r_tcnt;

        case (r_state)
            S_IDLE: begin
                w_stop = 1'b0;
                if (bus.en_single || bus.en_twin) begin
                    w_twin  = ~bus.en_single;
                    w_exc   = 4'd0;
                    w_det   = 4'd1;
                    w_plane = 1'b0;
                    w_idx   = 10'd0;
                    w_err   = 1'b0;
                    w_state = S_SETUP;
                end
            end

            S_SETUP: begin
                w_scnt  = c_settle_ld;
                w_state = S_SETTLE;
            end

            S_SETTLE: begin
                if (r_scnt == 8'd0) begin
                    w_adc_start = 1'b1;
                    w_tcnt      = 8'd0;
                    w_state     = S_CONV;
                end else begin
                    w_scnt = r_scnt - 8'd1;
                end
            end

            // r_tcnt holds the number of cycles elapsed since the trigger;
            // a done in the trigger cycle itself is deliberately ignored.
            S_CONV: begin
                if (r_adc_start) begin
                    w_tcnt = 8'd1;
                end else if (bus.adc_done) begin
                    w_valid = 1'b1;
                    w_state = S_NEXT;
                end else if (r_tcnt == c_timeout) begin
                    w_err   = 1'b1;
                    w_state = S_NEXT;
                end else begin
                    w_tcnt = r_tcnt + 8'd1;
                end
            end

            S_NEXT: begin
                if (w_last_pair) begin
                    if (r_twin && !r_plane) begin
                        w_plane = 1'b1;
                        w_exc   = 4'd0;
                        w_det   = 4'd1;
                        w_idx   = r_idx + 10'd1;
                        w_state = S_SETUP;
                    end else begin
                        w_frame_end = 1'b1;
                        w_state     = S_DONE;
                    end
                end else begin
                    if (r_det < c_last_det) begin
                        w_det = r_det + 4'd1;
                    end else begin
                        w_exc = r_exc + 4'd1;
                        w_det = r_exc + 4'd2;
                    end
                    w_idx   = r_idx + 10'd1;
                    w_state = S_SETUP;
                end
            end

            S_DONE: begin
                if (w_stop || !(bus.en_single || bus.en_twin)) begin
                    w_stop  = 1'b0;
                    w_state = S_IDLE;
                end else begin
                    w_exc   = 4'd0;
                    w_det   = 4'd1;
                    w_plane = 1'b0;
                    w_idx   = 10'd0;
                    w_err   = 1'b0;
                    w_state = S_SETUP;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_exc       <= 4'd0;
            r_det       <= 4'd0;
            r_plane     <= 1'b0;
            r_adc_start <= 1'b0;
            r_idx       <= 10'd0;
            r_valid     <= 1'b0;
            r_frame_end <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_stop      <= 1'b0;
            r_twin      <= 1'b0;
            r_scnt      <= 8'd0;
            r_tcnt      <= 8'd0;
        end else begin
            r_state     <= w_state;
            r_exc       <= w_exc;
            r_det       <= w_det;
            r_plane     <= w_plane;
            r_adc_start <= w_adc_start;
            r_idx       <= w_idx;
            r_valid     <= w_valid;
            r_frame_end <= w_frame_end;
            r_busy      <= w_busy;
            r_err       <= w_err;
            r_stop      <= w_stop;
            r_twin      <= w_twin;
            r_scnt      <= w_scnt;
            r_tcnt      <= w_tcnt;
        end
    end

    assign bus.exc_sel    = r_exc;
    assign bus.det_sel    = r_det;
    assign bus.plane      = r_plane;
    assign bus.adc_start  = r_adc_start;
    assign bus.meas_idx   = r_idx;
    assign bus.meas_valid = r_valid;
    assign bus.frame_end  = r_frame_end;
    assign bus.busy       = r_busy;
    assign bus.adc_err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_meas_sequencer.sv
// ---------------------------------------------------------------------------
// Module : tb_meas_sequencer
// Brief  : Scoreboard bench for meas_sequencer with a scripted ADC responder.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_meas_sequencer;

    localparam int NELEC   = 12;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 255;
    localparam int PAIR_CYC = 1 + SETTLE + 2 + 1;

    localparam int W_FE     = 0;
    localparam int W_IDLE   = 1;
    localparam int W_ERR    = 2;
    localparam int W_START5 = 3;

    typedef struct packed {
        logic [9:0] idx;
        logic [3:0] exc;
        logic [3:0] det;
        logic       plane;
        logic       err;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    meas_sequencer_if bif ();

    meas_sequencer #(
        .NELEC   (NELEC),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.master)
    );

    always #5 clk = ~clk;

    rec_t exp_q[$];
    rec_t fe_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   withhold = -1;
    bit   sim_done = 1'b0;
    bit   pend     = 1'b0;
    int   t0;

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: answers one cycle after each trigger; for the withheld index
    // it only fires a stray done inside the trigger cycle, which must be ignored.
    initial begin
        bif.adc_done = 1'b0;
        forever begin
            @(negedge clk);
            bif.adc_done = pend || (bif.adc_start && !rst && int'(bif.meas_idx) == withhold);
            pend = bif.adc_start && !rst && int'(bif.meas_idx) != withhold;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_pairs(input bit twin, input int skip, input int upto);
        int k = 0;
        for (int p = 0; p <= (twin ? 1 : 0); p++)
            for (int e = 0; e < NELEC - 1; e++)
                for (int d = e + 1; d < NELEC; d++) begin
                    if (k <= upto && k != skip)
                        exp_q.push_back('{idx: 10'(k), exc: 4'(e), det: 4'(d),
                                          plane: 1'(p), err: (skip >= 0 && k > skip)});
                    k++;
                end
    endtask

    task automatic push_fe(input int idx, input bit plane, input bit err);
        fe_q.push_back('{idx: 10'(idx), exc: 4'd0, det: 4'd0, plane: plane, err: err});
    endtask

    function automatic bit cond(input int what);
        case (what)
            W_FE:     return bif.frame_end;
            W_IDLE:   return !bif.busy;
            W_ERR:    return bif.adc_err;
            default:  return bif.adc_start && bif.meas_idx == 10'd5;
        endcase
    endfunction

    task automatic wait_for(input int what, input int limit, input string name);
        int n = 0;
        while (!cond(what) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!cond(what)) begin
            errors++;
            $display("FAIL %s actual=not_reached required=reached_within_%0d", name, limit);
        end
    endtask

    task automatic wait_idx(input int idx, input int limit, input string name);
        int n = 0;
        while (int'(bif.meas_idx) != idx && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(bif.meas_idx), 32'(idx));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},       32'(bif.busy),       0);
        chk({tag, "_adc_start"},  32'(bif.adc_start),  0);
        chk({tag, "_meas_valid"}, 32'(bif.meas_valid), 0);
        chk({tag, "_frame_end"},  32'(bif.frame_end),  0);
        chk({tag, "_adc_err"},    32'(bif.adc_err),    0);
        chk({tag, "_exc"},        32'(bif.exc_sel),    0);
        chk({tag, "_det"},        32'(bif.det_sel),    0);
        chk({tag, "_plane"},      32'(bif.plane),      0);
        chk({tag, "_idx"},        32'(bif.meas_idx),   0);
    endtask

    initial begin
        bif.en_single = 1'b0;
        bif.en_twin   = 1'b0;
        bif.stop_req  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        fork
            begin : monitor
                rec_t a, e;
                int   prev_idx = -10;
                int   prev_cyc = 0;
                while (!sim_done) begin
                    @(negedge clk);
                    if (!rst && bif.meas_valid) begin
                        a = '{idx: bif.meas_idx, exc: bif.exc_sel, det: bif.det_sel,
                              plane: bif.plane, err: bif.adc_err};
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_valid actual idx=%0d required=no_strobe", a.idx);
                        end else begin
                            e = exp_q.pop_front();
                            if (a !== e) begin
                                errors++;
                                $display("FAIL pair actual idx=%0d exc=%0d det=%0d plane=%0d err=%0d required idx=%0d exc=%0d det=%0d plane=%0d err=%0d",
                                         a.idx, a.exc, a.det, a.plane, a.err, e.idx, e.exc, e.det, e.plane, e.err);
                            end
                        end
                        if (int'(bif.meas_idx) == prev_idx + 1)
                            chk("pair_latency", 32'(cyc - prev_cyc), 32'(PAIR_CYC));
                        prev_idx = int'(bif.meas_idx);
                        prev_cyc = cyc;
                    end
                    if (!rst && bif.frame_end) begin
                        a = '{idx: bif.meas_idx, exc: 4'd0, det: 4'd0,
                              plane: bif.plane, err: bif.adc_err};
                        checks++;
                        if (fe_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_frame_end actual idx=%0d required=no_strobe", a.idx);
                        end else begin
                            e = fe_q.pop_front();
                            if (a !== e) begin
                                errors++;
                                $display("FAIL frame_end actual idx=%0d plane=%0d err=%0d required idx=%0d plane=%0d err=%0d",
                                         a.idx, a.plane, a.err, e.idx, e.plane, e.err);
                            end
                        end
                    end
                end
            end

            begin : stimulus
                // Single plane: two back-to-back frames, stop raised mid second frame.
                push_pairs(1'b0, -1, 999);
                push_pairs(1'b0, -1, 999);
                push_fe(65, 1'b0, 1'b0);
                push_fe(65, 1'b0, 1'b0);
                bif.stop_req = 1'b1;
                @(negedge clk);
                bif.stop_req = 1'b0;
                bif.en_single = 1'b1;
                wait_for(W_FE, 1200, "single_frame1_end");
                wait_idx(10, 200, "single_frame2_idx10");
                bif.stop_req = 1'b1;
                @(negedge clk);
                bif.stop_req = 1'b0;
                wait_for(W_FE, 1200, "single_frame2_end");
                @(negedge clk);
                chk("stop_busy_after_frame", 32'(bif.busy), 0);
                bif.en_single = 1'b0;
                chk("single_drained", 32'(exp_q.size()), 0);

                // Twin plane; enable dropped mid-frame must not truncate it.
                push_pairs(1'b1, -1, 999);
                push_fe(131, 1'b1, 1'b0);
                bif.en_twin = 1'b1;
                wait_idx(50, 600, "twin_idx50");
                bif.en_twin = 1'b0;
                wait_for(W_FE, 1500, "twin_frame_end");
                wait_for(W_IDLE, 4, "twin_idle");
                chk("twin_drained", 32'(exp_q.size()), 0);

                // ADC timeout on pair 5.
                withhold = 5;
                push_pairs(1'b0, 5, 999);
                push_fe(65, 1'b0, 1'b1);
                bif.en_single = 1'b1;
                wait_for(W_START5, 200, "start_idx5");
                t0 = cyc;
                wait_for(W_ERR, 300, "adc_err_rise");
                chk("timeout_cycles", 32'(cyc - t0), 32'(TIMEOUT + 1));
                wait_idx(30, 400, "timeout_idx30");
                bif.en_single = 1'b0;
                wait_for(W_FE, 800, "timeout_frame_end");
                wait_for(W_IDLE, 4, "timeout_idle");
                chk("err_sticky_idle", 32'(bif.adc_err), 1);
                withhold = -1;

                // Reset while settling pair 20, then restart.
                push_pairs(1'b0, -1, 19);
                bif.en_single = 1'b1;
                @(negedge clk);
                chk("err_clear_on_start", 32'(bif.adc_err), 0);
                chk("busy_on_start", 32'(bif.busy), 1);
                wait_idx(20, 300, "abort_idx20");
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                chk_all_zero("abort");
                push_pairs(1'b0, -1, 999);
                push_fe(65, 1'b0, 1'b0);
                rst = 1'b0;
                wait_idx(30, 400, "restart_idx30");
                bif.en_single = 1'b0;
                wait_for(W_FE, 800, "restart_frame_end");
                wait_for(W_IDLE, 4, "restart_idle");

                chk("exp_q_empty", 32'(exp_q.size()), 0);
                chk("fe_q_empty", 32'(fe_q.size()), 0);
                sim_done = 1'b1;
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
